// File: rtl/xt_bus_arbiter_if.sv
// CPU, DMA and shared system-bus signals around the XT bus arbiter.
// The arbiter connects through the slave modport; the surrounding system drives the master side.
interface xt_bus_arbiter_if;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_ale;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_iom;
    logic        cpu_inta_n;
    logic        cpu_lock;
    logic        cpu_ready;

    logic        dma_hrq;
    logic        dma_hlda;
    logic [19:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_rd_n;
    logic        dma_wr_n;
    logic        dma_iom;

    logic [19:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_ale;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_iom;
    logic        bus_inta_n;
    logic        bus_ready;
    logic        aen;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_ale, cpu_rd_n, cpu_wr_n, cpu_iom, cpu_inta_n, cpu_lock,
        input  dma_hrq, dma_addr, dma_dout, dma_rd_n, dma_wr_n, dma_iom,
        input  bus_ready,
        output cpu_ready, dma_hlda,
        output bus_addr, bus_dout, bus_ale, bus_rd_n, bus_wr_n, bus_iom, bus_inta_n, aen
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_ale, cpu_rd_n, cpu_wr_n, cpu_iom, cpu_inta_n, cpu_lock,
        output dma_hrq, dma_addr, dma_dout, dma_rd_n, dma_wr_n, dma_iom,
        output bus_ready,
        input  cpu_ready, dma_hlda,
        input  bus_addr, bus_dout, bus_ale, bus_rd_n, bus_wr_n, bus_iom, bus_inta_n, aen
    );
endinterface

// File: rtl/xt_bus_arbiter.sv
// Hands the XT system bus between the CPU and an 8237-style DMA controller,
// with an idle settle window before HLDA and a guaranteed CPU window after release.
module xt_bus_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned CPU_MIN_CYCLES = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    xt_bus_arbiter_if.slave io
);
    typedef enum logic [1:0] {
        CPU_OWN,
        SETTLE,
        DMA_OWN,
        RETURN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  settle_cnt_q;
    logic [3:0]  min_cnt_q;
    logic        pending_q;
    logic [19:0] pend_addr_q;
    logic        pend_iom_q;
    logic        hlda_q;
    logic        aen_q;
    logic        cpu_busy;

    logic [19:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_ale;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_iom;
    logic        bus_inta_n;
    logic        cpu_ready;

    assign cpu_busy = io.cpu_ale | ~io.cpu_rd_n | ~io.cpu_wr_n | ~io.cpu_inta_n;

    // NOTE: every output and next-state variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: begin
                if (io.dma_hrq && !cpu_busy && !io.cpu_lock && (min_cnt_q == 4'd0) && !pending_q)
                    state_d = SETTLE;
            end
            SETTLE: begin
                if (!io.dma_hrq)
                    state_d = RETURN;
                else if (settle_cnt_q == 4'd0)
                    state_d = DMA_OWN;
            end
            DMA_OWN: begin
                if (!io.dma_hrq)
                    state_d = RETURN;
            end
            RETURN:  state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= CPU_OWN;
            settle_cnt_q <= 4'd0;
            min_cnt_q    <= 4'd0;
            pending_q    <= 1'b0;
            hlda_q       <= 1'b0;
            aen_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            hlda_q  <= (state_d == DMA_OWN);
            aen_q   <= (state_d != CPU_OWN);

            if (state_q != SETTLE && state_d == SETTLE)
                settle_cnt_q <= 4'(SETTLE_CYCLES - 1);
            else if (state_q == SETTLE && settle_cnt_q != 4'd0)
                settle_cnt_q <= settle_cnt_q - 4'd1;

            if (state_q == RETURN)
                min_cnt_q <= 4'(CPU_MIN_CYCLES);
            else if (state_q == CPU_OWN && min_cnt_q != 4'd0)
                min_cnt_q <= min_cnt_q - 4'd1;

            // The replay clock itself is the first CPU_OWN clock with pending set.
            if (state_q != CPU_OWN) begin
                if (io.cpu_ale)
                    pending_q <= 1'b1;
            end else if (pending_q) begin
                pending_q <= 1'b0;
            end
        end
    end

    // NOTE: the captured address/iom are plain datapath registers only ever read while pending_q is set, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (state_q != CPU_OWN && io.cpu_ale) begin
            pend_addr_q <= io.cpu_addr;
            pend_iom_q  <= io.cpu_iom;
        end
    end

    always_comb begin
        bus_addr   = io.cpu_addr;
        bus_dout   = io.cpu_dout;
        bus_iom    = io.cpu_iom;
        bus_ale    = 1'b0;
        bus_rd_n   = 1'b1;
        bus_wr_n   = 1'b1;
        bus_inta_n = 1'b1;
        cpu_ready  = 1'b0;
        case (state_q)
            CPU_OWN: begin
                if (pending_q) begin
                    bus_ale  = 1'b1;
                    bus_addr = pend_addr_q;
                    bus_iom  = pend_iom_q;
                end else begin
                    bus_ale    = io.cpu_ale;
                    bus_rd_n   = io.cpu_rd_n;
                    bus_wr_n   = io.cpu_wr_n;
                    bus_inta_n = io.cpu_inta_n;
                    cpu_ready  = io.bus_ready;
                end
            end
            DMA_OWN: begin
                bus_addr = io.dma_addr;
                bus_dout = io.dma_dout;
                bus_iom  = io.dma_iom;
                bus_rd_n = io.dma_rd_n;
                bus_wr_n = io.dma_wr_n;
            end
            default: ;
        endcase
        // Reset must silence the bus immediately, before the state register is cleared.
        if (RESET) begin
            bus_ale    = 1'b0;
            bus_rd_n   = 1'b1;
            bus_wr_n   = 1'b1;
            bus_inta_n = 1'b1;
            cpu_ready  = 1'b0;
        end
    end

    assign io.bus_addr   = bus_addr;
    assign io.bus_dout   = bus_dout;
    assign io.bus_ale    = bus_ale;
    assign io.bus_rd_n   = bus_rd_n;
    assign io.bus_wr_n   = bus_wr_n;
    assign io.bus_iom    = bus_iom;
    assign io.bus_inta_n = bus_inta_n;
    assign io.cpu_ready  = cpu_ready;
    assign io.dma_hlda   = hlda_q;
    assign io.aen        = aen_q;
endmodule

// File: tb/tb_xt_bus_arbiter.sv
// Self-checking bench for xt_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based ownership model.
module tb_xt_bus_arbiter;
    localparam int SETTLE_CYCLES  = 2;
    localparam int CPU_MIN_CYCLES = 4;

    logic CLK = 1'b0;
    logic RESET;

    xt_bus_arbiter_if bus_if ();

    xt_bus_arbiter #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CPU_MIN_CYCLES(CPU_MIN_CYCLES)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .io   (bus_if)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Ownership model: who holds the bus, plus absolute cycle numbers for the
    // moment HLDA is due and the moment the CPU guarantee expires.
    typedef enum {O_CPU, O_SETTLING, O_DMA, O_HANDBACK} owner_t;
    owner_t      owner       = O_CPU;
    int          cyc         = 0;
    int          grant_at    = 0;
    int          guard_end   = 0;
    logic        pend        = 1'b0;
    logic [19:0] pend_addr   = 20'd0;
    logic        pend_iom    = 1'b0;
    logic        model_valid = 1'b0;
    logic        busy_now;

    assign busy_now = bus_if.cpu_ale | ~bus_if.cpu_rd_n | ~bus_if.cpu_wr_n | ~bus_if.cpu_inta_n;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET) begin
            owner       <= O_CPU;
            guard_end   <= 0;
            pend        <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            case (owner)
                O_CPU: begin
                    if (pend)
                        pend <= 1'b0;
                    else if (bus_if.dma_hrq && !busy_now && !bus_if.cpu_lock && cyc >= guard_end) begin
                        owner    <= O_SETTLING;
                        grant_at <= cyc + 1 + SETTLE_CYCLES;
                    end
                end
                O_SETTLING: begin
                    if (!bus_if.dma_hrq)      owner <= O_HANDBACK;
                    else if (cyc + 1 == grant_at) owner <= O_DMA;
                end
                O_DMA: begin
                    if (!bus_if.dma_hrq) owner <= O_HANDBACK;
                end
                default: begin
                    owner     <= O_CPU;
                    guard_end <= cyc + 1 + CPU_MIN_CYCLES;
                end
            endcase
            if (owner != O_CPU && bus_if.cpu_ale) begin
                pend      <= 1'b1;
                pend_addr <= bus_if.cpu_addr;
                pend_iom  <= bus_if.cpu_iom;
            end
        end
    end

    typedef struct packed {
        logic        aen;
        logic        hlda;
        logic        ready;
        logic        ale;
        logic        rd_n;
        logic        wr_n;
        logic        inta_n;
        logic        iom;
        logic [19:0] addr;
        logic [7:0]  dout;
        logic        chk_addr;
        logic        chk_data;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        e.aen      = (owner != O_CPU);
        e.hlda     = (owner == O_DMA);
        e.ready    = 1'b0;
        e.ale      = 1'b0;
        e.rd_n     = 1'b1;
        e.wr_n     = 1'b1;
        e.inta_n   = 1'b1;
        e.iom      = bus_if.cpu_iom;
        e.addr     = bus_if.cpu_addr;
        e.dout     = bus_if.cpu_dout;
        e.chk_addr = 1'b0;
        e.chk_data = 1'b0;
        if (owner == O_CPU && pend) begin
            e.ale      = 1'b1;
            e.addr     = pend_addr;
            e.iom      = pend_iom;
            e.chk_addr = 1'b1;
        end else if (owner == O_CPU) begin
            e.ale      = bus_if.cpu_ale;
            e.rd_n     = bus_if.cpu_rd_n;
            e.wr_n     = bus_if.cpu_wr_n;
            e.inta_n   = bus_if.cpu_inta_n;
            e.ready    = bus_if.bus_ready;
            e.chk_addr = 1'b1;
            e.chk_data = 1'b1;
        end else if (owner == O_DMA) begin
            e.addr     = bus_if.dma_addr;
            e.dout     = bus_if.dma_dout;
            e.iom      = bus_if.dma_iom;
            e.rd_n     = bus_if.dma_rd_n;
            e.wr_n     = bus_if.dma_wr_n;
            e.chk_addr = 1'b1;
            e.chk_data = 1'b1;
        end
        if (RESET) begin
            e.ale    = 1'b0;
            e.rd_n   = 1'b1;
            e.wr_n   = 1'b1;
            e.inta_n = 1'b1;
            e.ready  = 1'b0;
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (model_valid) begin
            check("cyc_aen",    32'(bus_if.aen),        32'(expect_now().aen));
            check("cyc_hlda",   32'(bus_if.dma_hlda),   32'(expect_now().hlda));
            check("cyc_ready",  32'(bus_if.cpu_ready),  32'(expect_now().ready));
            check("cyc_ale",    32'(bus_if.bus_ale),    32'(expect_now().ale));
            check("cyc_rd_n",   32'(bus_if.bus_rd_n),   32'(expect_now().rd_n));
            check("cyc_wr_n",   32'(bus_if.bus_wr_n),   32'(expect_now().wr_n));
            check("cyc_inta_n", 32'(bus_if.bus_inta_n), 32'(expect_now().inta_n));
            if (expect_now().chk_addr) begin
                check("cyc_addr", 32'(bus_if.bus_addr), 32'(expect_now().addr));
                check("cyc_iom",  32'(bus_if.bus_iom),  32'(expect_now().iom));
            end
            if (expect_now().chk_data)
                check("cyc_dout", 32'(bus_if.bus_dout), 32'(expect_now().dout));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int cpu_t;
        int cpu_step;
        int kind;

        RESET             = 1'b1;
        bus_if.cpu_addr   = 20'd0;
        bus_if.cpu_dout   = 8'd0;
        bus_if.cpu_ale    = 1'b1;
        bus_if.cpu_rd_n   = 1'b0;
        bus_if.cpu_wr_n   = 1'b1;
        bus_if.cpu_iom    = 1'b0;
        bus_if.cpu_inta_n = 1'b1;
        bus_if.cpu_lock   = 1'b0;
        bus_if.dma_hrq    = 1'b0;
        bus_if.dma_addr   = 20'd0;
        bus_if.dma_dout   = 8'd0;
        bus_if.dma_rd_n   = 1'b1;
        bus_if.dma_wr_n   = 1'b1;
        bus_if.dma_iom    = 1'b0;
        bus_if.bus_ready  = 1'b1;

        // Reset state, with CPU strobes active to prove they are blocked.
        step(3);
        settle();
        check("rst_aen",   32'(bus_if.aen),       32'd0);
        check("rst_hlda",  32'(bus_if.dma_hlda),  32'd0);
        check("rst_ready", 32'(bus_if.cpu_ready), 32'd0);
        check("rst_ale",   32'(bus_if.bus_ale),   32'd0);
        check("rst_rd_n",  32'(bus_if.bus_rd_n),  32'd1);
        bus_if.cpu_ale  = 1'b0;
        bus_if.cpu_rd_n = 1'b1;
        RESET           = 1'b0;
        step(2);

        // Grant timing from an idle CPU.
        bus_if.dma_hrq  = 1'b1;
        bus_if.dma_addr = 20'hABCDE;
        bus_if.dma_rd_n = 1'b0;
        step();
        settle();
        check("grant_aen_c1",  32'(bus_if.aen),      32'd1);
        check("grant_hlda_c1", 32'(bus_if.dma_hlda), 32'd0);
        step();
        settle();
        check("grant_hlda_c2", 32'(bus_if.dma_hlda), 32'd0);
        step();
        settle();
        check("grant_hlda_c3", 32'(bus_if.dma_hlda), 32'd1);
        check("grant_addr",    32'(bus_if.bus_addr), 32'h000ABCDE);
        check("grant_rd_n",    32'(bus_if.bus_rd_n), 32'd0);
        check("grant_ready",   32'(bus_if.cpu_ready), 32'd0);

        // Release and the guaranteed CPU window.
        bus_if.dma_hrq  = 1'b0;
        bus_if.dma_rd_n = 1'b1;
        step();
        settle();
        check("rel_hlda", 32'(bus_if.dma_hlda), 32'd0);
        check("rel_aen",  32'(bus_if.aen),      32'd1);
        bus_if.dma_hrq = 1'b1;
        step();
        settle();
        check("rel_aen_cpu", 32'(bus_if.aen), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            settle();
            check("guard_aen",  32'(bus_if.aen),      32'd0);
            check("guard_hlda", 32'(bus_if.dma_hlda), 32'd0);
        end
        step();
        settle();
        check("guard_over_aen", 32'(bus_if.aen), 32'd1);
        step(2);
        settle();
        check("guard_over_hlda", 32'(bus_if.dma_hlda), 32'd1);
        bus_if.dma_hrq = 1'b0;
        step(8);

        // Settle aborted by an early hrq drop: no HLDA pulse.
        bus_if.dma_hrq = 1'b1;
        step();
        settle();
        check("abort_aen", 32'(bus_if.aen), 32'd1);
        bus_if.dma_hrq = 1'b0;
        step();
        settle();
        check("abort_ret_aen",  32'(bus_if.aen),      32'd1);
        check("abort_ret_hlda", 32'(bus_if.dma_hlda), 32'd0);
        step();
        settle();
        check("abort_cpu_aen", 32'(bus_if.aen), 32'd0);
        step(6);

        // CPU read started on the same clock as hrq wins the bus.
        bus_if.cpu_ale  = 1'b1;
        bus_if.cpu_addr = 20'hF0000;
        bus_if.cpu_iom  = 1'b0;
        bus_if.dma_hrq  = 1'b1;
        settle();
        check("race_ale",  32'(bus_if.bus_ale),  32'd1);
        check("race_addr", 32'(bus_if.bus_addr), 32'h000F0000);
        step();
        bus_if.cpu_ale   = 1'b0;
        bus_if.cpu_rd_n  = 1'b0;
        bus_if.bus_ready = 1'b0;
        settle();
        check("race_aen_t2", 32'(bus_if.aen),       32'd0);
        check("race_rd_n",   32'(bus_if.bus_rd_n),  32'd0);
        check("race_wait",   32'(bus_if.cpu_ready), 32'd0);
        step();
        bus_if.bus_ready = 1'b1;
        settle();
        check("race_aen_t3", 32'(bus_if.aen),       32'd0);
        check("race_ready",  32'(bus_if.cpu_ready), 32'd1);
        step();
        bus_if.cpu_rd_n = 1'b1;
        settle();
        check("race_aen_t4", 32'(bus_if.aen), 32'd0);
        step();
        settle();
        check("race_aen_after", 32'(bus_if.aen), 32'd1);
        step(2);
        settle();
        check("race_hlda", 32'(bus_if.dma_hlda), 32'd1);

        // CPU address phase during DMA is held and replayed after release.
        bus_if.dma_wr_n = 1'b0;
        bus_if.cpu_ale  = 1'b1;
        bus_if.cpu_addr = 20'h12345;
        bus_if.cpu_iom  = 1'b1;
        settle();
        check("pend_ready_dma", 32'(bus_if.cpu_ready), 32'd0);
        check("pend_ale_dma",   32'(bus_if.bus_ale),   32'd0);
        step();
        bus_if.cpu_ale  = 1'b0;
        bus_if.cpu_addr = 20'h00000;
        bus_if.cpu_iom  = 1'b0;
        bus_if.cpu_rd_n = 1'b0;
        settle();
        check("pend_ready_wait", 32'(bus_if.cpu_ready), 32'd0);
        check("pend_dma_rd_n",   32'(bus_if.bus_rd_n),  32'd1);
        check("pend_dma_wr_n",   32'(bus_if.bus_wr_n),  32'd0);
        bus_if.dma_hrq = 1'b0;
        step();
        settle();
        check("pend_ret_ready", 32'(bus_if.cpu_ready), 32'd0);
        check("pend_ret_rd_n",  32'(bus_if.bus_rd_n),  32'd1);
        check("pend_ret_aen",   32'(bus_if.aen),       32'd1);
        step();
        settle();
        check("replay_ale",   32'(bus_if.bus_ale),   32'd1);
        check("replay_addr",  32'(bus_if.bus_addr),  32'h00012345);
        check("replay_iom",   32'(bus_if.bus_iom),   32'd1);
        check("replay_rd_n",  32'(bus_if.bus_rd_n),  32'd1);
        check("replay_ready", 32'(bus_if.cpu_ready), 32'd0);
        check("replay_aen",   32'(bus_if.aen),       32'd0);
        step();
        settle();
        check("after_ale",   32'(bus_if.bus_ale),   32'd0);
        check("after_rd_n",  32'(bus_if.bus_rd_n),  32'd0);
        check("after_ready", 32'(bus_if.cpu_ready), 32'd1);
        bus_if.cpu_rd_n = 1'b1;
        bus_if.dma_wr_n = 1'b1;
        step(8);

        // LOCK holds off the grant.
        bus_if.cpu_lock = 1'b1;
        bus_if.dma_hrq  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            settle();
            check("lock_hlda", 32'(bus_if.dma_hlda), 32'd0);
            check("lock_aen",  32'(bus_if.aen),      32'd0);
        end
        bus_if.cpu_lock = 1'b0;
        step();
        settle();
        check("unlock_aen", 32'(bus_if.aen), 32'd1);
        step(2);
        settle();
        check("unlock_hlda", 32'(bus_if.dma_hlda), 32'd1);

        // Reset in the middle of a DMA grant.
        RESET = 1'b1;
        step();
        settle();
        check("dmarst_hlda",  32'(bus_if.dma_hlda),  32'd0);
        check("dmarst_aen",   32'(bus_if.aen),       32'd0);
        check("dmarst_rd_n",  32'(bus_if.bus_rd_n),  32'd1);
        check("dmarst_ready", 32'(bus_if.cpu_ready), 32'd0);
        RESET          = 1'b0;
        bus_if.dma_hrq = 1'b0;
        step();
        settle();
        check("dmarst_cpu_aen",   32'(bus_if.aen),       32'd0);
        check("dmarst_cpu_ready", 32'(bus_if.cpu_ready), 32'd1);

        // Randomized traffic against the model.
        cpu_t    = 0;
        cpu_step = 0;
        kind     = 0;
        for (int i = 0; i < 3000; i++) begin
            bus_if.cpu_ale    = 1'b0;
            bus_if.cpu_rd_n   = 1'b1;
            bus_if.cpu_wr_n   = 1'b1;
            bus_if.cpu_inta_n = 1'b1;
            if (cpu_t == 0) begin
                case (cpu_step)
                    0: begin
                        cpu_step        = 1;
                        cpu_t           = 1;
                        bus_if.cpu_addr = 20'($urandom);
                        bus_if.cpu_dout = 8'($urandom);
                        bus_if.cpu_iom  = 1'($urandom);
                    end
                    1: begin
                        cpu_step = 2;
                        cpu_t    = $urandom_range(1, 4);
                        kind     = $urandom_range(0, 2);
                    end
                    default: begin
                        cpu_step = 0;
                        cpu_t    = $urandom_range(1, 6);
                    end
                endcase
            end
            if (cpu_step == 1)
                bus_if.cpu_ale = 1'b1;
            else if (cpu_step == 2) begin
                if (kind == 0)      bus_if.cpu_rd_n   = 1'b0;
                else if (kind == 1) bus_if.cpu_wr_n   = 1'b0;
                else                bus_if.cpu_inta_n = 1'b0;
            end
            cpu_t--;

            if ($urandom_range(0, 7) == 0)  bus_if.dma_hrq  = ~bus_if.dma_hrq;
            if ($urandom_range(0, 31) == 0) bus_if.cpu_lock = ~bus_if.cpu_lock;
            bus_if.bus_ready = ($urandom_range(0, 3) != 0);
            bus_if.dma_addr  = 20'($urandom);
            bus_if.dma_dout  = 8'($urandom);
            bus_if.dma_rd_n  = 1'($urandom);
            bus_if.dma_wr_n  = 1'($urandom);
            bus_if.dma_iom   = 1'($urandom);
            RESET            = ($urandom_range(0, 249) == 0);
            step();
        end
        RESET = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
